// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC capture sequencer: state encoding, period floor, default widths.
package adc_capture_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int DIV_W_DEF   = 16;
  localparam int CNT_W_DEF   = 16;
  localparam int CAP_LAT_DEF = 2;
  localparam int MIN_PERIOD  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/adc_capture_controller_if.sv
// Captured-sample stream: single-entry register with ready/valid and end-of-frame marker.
interface adc_capture_controller_if
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;
  logic              data_out_last;
  logic              data_ready;

  modport master (output data_out, output data_out_valid, output data_out_last, input data_ready);
  modport slave  (input data_out, input data_out_valid, input data_out_last, output data_ready);

endinterface

// File: rtl/adc_sinc_gen.sv
// Conversion strobe generator: fires on launch, then every `period` cycles while enabled.
module adc_sinc_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             launch,
  input  logic             en,
  input  logic [DIV_W-1:0] period,
  output logic             sinc
);

  logic [DIV_W-1:0] cnt;

  // Reload with the full period so the terminal count lands exactly `period` cycles later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      sinc <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      sinc <= 1'b0;
    end else if (launch) begin
      cnt  <= period;
      sinc <= 1'b1;
    end else if (en) begin
      if (cnt == DIV_W'(1)) begin
        cnt  <= period;
        sinc <= 1'b1;
      end else begin
        cnt  <= cnt - DIV_W'(1);
        sinc <= 1'b0;
      end
    end else begin
      sinc <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_capture_controller.sv
// ADC capture sequencer: paces sinc, frames N samples, streams them out with overrun reporting.
// ADC_CAPTURE_TRIG_EN adds the ARM state and trigger_in rising-edge start.
//
// state    | meaning
// ST_IDLE  | waiting for start; config latched on start
// ST_ARM   | waiting for trigger_in rising edge
// ST_RUN   | issuing sinc every period until N pulses
// ST_FLUSH | draining capture pipeline and output register
module adc_capture_controller
  import adc_capture_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int CAP_LAT = CAP_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              trigger_in,
  input  logic              cfg_trig_mode,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_num_samples,
  input  logic [DATA_W-1:0] adc_data,
  output logic              sinc,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [CNT_W-1:0]  sample_count,
  adc_capture_controller_if.master strm
);

  state_t             state;
  logic [DIV_W-1:0]   div_clamped, div_q, period_eff;
  logic [CNT_W-1:0]   num_q;
  logic [CAP_LAT-1:0] pipe_v, pipe_t;
  logic               launch_run, last_pulse, accept, cap, cap_tag, hs, flush_ok;

  assign div_clamped = (cfg_div < DIV_W'(MIN_PERIOD)) ? DIV_W'(MIN_PERIOD) : cfg_div;
  assign period_eff  = (state == ST_IDLE) ? div_clamped : div_q;
  assign accept      = (state == ST_IDLE) && start && !abort;
  assign last_pulse  = sinc && (state == ST_RUN) && (sample_count + CNT_W'(1) == num_q);
  assign cap         = pipe_v[CAP_LAT-1];
  assign cap_tag     = pipe_t[CAP_LAT-1];
  assign hs          = strm.data_out_valid && strm.data_ready;
  assign flush_ok    = (pipe_v == '0) && (!strm.data_out_valid || hs);

`ifdef ADC_CAPTURE_TRIG_EN
  logic trig_q, trig_edge;

  // Edge flag is registered, so a trigger seen in cycle r launches in r+2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_q    <= 1'b0;
      trig_edge <= 1'b0;
    end else begin
      trig_q    <= trigger_in;
      trig_edge <= trigger_in && !trig_q;
    end
  end

  assign launch_run = !abort &&
                      ((accept && (cfg_num_samples != '0) && !cfg_trig_mode) ||
                       ((state == ST_ARM) && trig_edge));
`else
  logic unused_trig;
  assign unused_trig = trigger_in ^ cfg_trig_mode;
  assign launch_run  = accept && (cfg_num_samples != '0);
`endif

  adc_sinc_gen #(.DIV_W(DIV_W)) u_sinc_gen (
    .clk    (clk),
    .reset  (reset),
    .clear  (abort),
    .launch (launch_run),
    .en     (state == ST_RUN),
    .period (period_eff),
    .sinc   (sinc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      div_q        <= '0;
      num_q        <= '0;
      sample_count <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              div_q        <= div_clamped;
              num_q        <= cfg_num_samples;
              sample_count <= '0;
              if (cfg_num_samples == '0) begin
                done <= 1'b1;
              end else if (launch_run) begin
                state <= ST_RUN;
                busy  <= 1'b1;
              end
`ifdef ADC_CAPTURE_TRIG_EN
              else begin
                state <= ST_ARM;
                busy  <= 1'b1;
              end
`endif
            end
          end
`ifdef ADC_CAPTURE_TRIG_EN
          ST_ARM: begin
            if (trig_edge) state <= ST_RUN;
          end
`endif
          ST_RUN: begin
            if (sinc && (sample_count != num_q)) sample_count <= sample_count + CNT_W'(1);
            if (last_pulse) state <= ST_FLUSH;
          end
          ST_FLUSH: begin
            if (flush_ok) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // A capture into a full, stalled register is dropped but its last tag is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_v              <= '0;
      pipe_t              <= '0;
      strm.data_out       <= '0;
      strm.data_out_valid <= 1'b0;
      strm.data_out_last  <= 1'b0;
      overrun             <= 1'b0;
    end else if (abort) begin
      pipe_v              <= '0;
      pipe_t              <= '0;
      strm.data_out_valid <= 1'b0;
      strm.data_out_last  <= 1'b0;
    end else begin
      pipe_v <= (pipe_v << 1) | CAP_LAT'(sinc);
      pipe_t <= (pipe_t << 1) | CAP_LAT'(last_pulse);
      if (accept) overrun <= 1'b0;
      if (cap) begin
        if (!strm.data_out_valid || strm.data_ready) begin
          strm.data_out       <= adc_data;
          strm.data_out_valid <= 1'b1;
          strm.data_out_last  <= cap_tag;
        end else begin
          overrun            <= 1'b1;
          strm.data_out_last <= strm.data_out_last | cap_tag;
        end
      end else if (hs) begin
        strm.data_out_valid <= 1'b0;
        strm.data_out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_controller.sv
// Scoreboard bench for adc_capture_controller: expected words queued at stimulus, popped on handshake.
module tb_adc_capture_controller;
  import adc_capture_pkg::*;

  localparam int LAT = 2;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        reset, start, abort, trigger_in, cfg_trig_mode;
  logic [15:0] cfg_div, cfg_num_samples, sample_count;
  logic [31:0] adc_data;
  logic        sinc, busy, done, overrun;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          sinc_q[$];
  int          done_q[$];
  word_t       exp_q[$];
  word_t       mon_w;
  int          t, t2, r, first;

  adc_capture_controller_if #(.DATA_W(32)) strm ();

  adc_capture_controller dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .trigger_in      (trigger_in),
    .cfg_trig_mode   (cfg_trig_mode),
    .cfg_div         (cfg_div),
    .cfg_num_samples (cfg_num_samples),
    .adc_data        (adc_data),
    .sinc            (sinc),
    .busy            (busy),
    .done            (done),
    .overrun         (overrun),
    .sample_count    (sample_count),
    .strm            (strm.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input int c);
    return 32'h5A00_0000 + 32'(c) * 32'h0001_0101;
  endfunction

  assign adc_data = pat(cyc);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (sinc) sinc_q.push_back(cyc);
      if (done) done_q.push_back(cyc);
      if (strm.data_out_valid && strm.data_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_hs", 64'(1), 64'(0));
        end else begin
          mon_w = exp_q.pop_front();
          chk("hs_data", 64'(strm.data_out), 64'(mon_w.data));
          chk("hs_last", 64'(strm.data_out_last), 64'(mon_w.last));
        end
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic mode, input int div, input int n, output int ts);
    sinc_q.delete();
    done_q.delete();
    cfg_trig_mode   = mode;
    cfg_div         = 16'(div);
    cfg_num_samples = 16'(n);
    start           = 1'b1;
    ts              = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic expect_frame(input int f, input int p, input int n);
    word_t w;
    for (int k = 0; k < n; k++) begin
      w.data = pat(f + k * p + LAT);
      w.last = (k == n - 1);
      exp_q.push_back(w);
    end
  endtask

  task automatic check_sincs(input string tag, input int f, input int p, input int n);
    chk({tag, "_sinc_cnt"}, 64'(sinc_q.size()), 64'(n));
    for (int k = 0; k < n; k++)
      if (k < sinc_q.size()) chk({tag, "_sinc_cyc"}, 64'(sinc_q[k]), 64'(f + k * p));
  endtask

  task automatic check_done(input string tag, input int exp_cyc);
    chk({tag, "_done_cnt"}, 64'(done_q.size()), 64'(1));
    if (done_q.size() > 0) chk({tag, "_done_cyc"}, 64'(done_q[0]), 64'(exp_cyc));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; trigger_in = 1'b0;
    cfg_trig_mode = 1'b0; cfg_div = '0; cfg_num_samples = '0;
    strm.data_ready = 1'b0;
    tick(3);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_sinc", 64'(sinc), 64'(0));
    chk("rst_valid", 64'(strm.data_out_valid), 64'(0));
    chk("rst_count", 64'(sample_count), 64'(0));
    reset = 1'b1;
    tick(2);

    // immediate capture: div 4, three samples
    strm.data_ready = 1'b1;
    launch(1'b0, 4, 3, t);
    expect_frame(t + 1, 4, 3);
    chk("imm_busy_t1", 64'(busy), 64'(1));
    chk("imm_sinc_t1", 64'(sinc), 64'(1));
    tick(16);
    check_sincs("imm", t + 1, 4, 3);
    check_done("imm", t + 1 + 2 * 4 + LAT + 2);
    chk("imm_overrun", 64'(overrun), 64'(0));
    chk("imm_count", 64'(sample_count), 64'(3));
    chk("imm_busy_end", 64'(busy), 64'(0));
    chk("imm_q_empty", 64'(exp_q.size()), 64'(0));

    // triggered capture: trigger rises at t+4
    launch(1'b1, 3, 2, t);
`ifdef ADC_CAPTURE_TRIG_EN
    first = t + 6;
`else
    first = t + 1;
`endif
    expect_frame(first, 3, 2);
    tick(3);
    r = cyc;
    chk("trg_sinc_before_edge", 64'(sinc_q.size()), 64'((first < r) ? 1 : 0));
    chk("trg_busy", 64'(busy), 64'(1));
    trigger_in = 1'b1;
    tick(2);
    trigger_in = 1'b0;
    tick(14);
    check_sincs("trg", first, 3, 2);
    check_done("trg", first + 3 + LAT + 2);
    chk("trg_q_empty", 64'(exp_q.size()), 64'(0));

    // backpressure: stalled output, only the first word survives and inherits last
    strm.data_ready = 1'b0;
    launch(1'b0, 2, 4, t);
    mon_w.data = pat(t + 1 + LAT);
    mon_w.last = 1'b1;
    exp_q.push_back(mon_w);
    tick(9);
    chk("bp_overrun", 64'(overrun), 64'(1));
    chk("bp_valid_held", 64'(strm.data_out_valid), 64'(1));
    chk("bp_busy_held", 64'(busy), 64'(1));
    tick(1);
    strm.data_ready = 1'b1;
    tick(4);
    check_sincs("bp", t + 1, 2, 4);
    check_done("bp", t + 12);
    chk("bp_q_empty", 64'(exp_q.size()), 64'(0));

    // zero length
    launch(1'b0, 5, 0, t);
    chk("zero_busy", 64'(busy), 64'(0));
    chk("zero_done_t1", 64'(done), 64'(1));
    tick(6);
    chk("zero_sinc_cnt", 64'(sinc_q.size()), 64'(0));
    check_done("zero", t + 1);

    // abort after two of eight samples, then a fresh capture
    launch(1'b0, 4, 8, t);
    expect_frame(t + 1, 4, 1);
    exp_q[0].last = 1'b0;
    tick(6);
    chk("abt_count", 64'(sample_count), 64'(2));
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abt_busy", 64'(busy), 64'(0));
    chk("abt_valid", 64'(strm.data_out_valid), 64'(0));
    tick(12);
    chk("abt_sinc_cnt", 64'(sinc_q.size()), 64'(2));
    chk("abt_no_done", 64'(done_q.size()), 64'(0));
    chk("abt_q_empty", 64'(exp_q.size()), 64'(0));
    launch(1'b0, 5, 1, t2);
    expect_frame(t2 + 1, 5, 1);
    tick(8);
    check_sincs("abt_re", t2 + 1, 5, 1);
    check_done("abt_re", t2 + 1 + LAT + 2);

    // asynchronous reset in the middle of RUN
    strm.data_ready = 1'b0;
    launch(1'b0, 3, 5, t);
    tick(5);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_busy", 64'(busy), 64'(0));
    chk("ar_sinc", 64'(sinc), 64'(0));
    chk("ar_valid", 64'(strm.data_out_valid), 64'(0));
    chk("ar_last", 64'(strm.data_out_last), 64'(0));
    chk("ar_data", 64'(strm.data_out), 64'(0));
    chk("ar_done", 64'(done), 64'(0));
    chk("ar_overrun", 64'(overrun), 64'(0));
    chk("ar_count", 64'(sample_count), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    strm.data_ready = 1'b1;
    tick(2);
    chk("ar_state_idle", 64'(dut.state), 64'(ST_IDLE));
    chk("ar_busy_after", 64'(busy), 64'(0));
    launch(1'b0, 2, 2, t);
    expect_frame(t + 1, 2, 2);
    tick(10);
    check_sincs("ar_re", t + 1, 2, 2);
    check_done("ar_re", t + 1 + 2 + LAT + 2);
    chk("ar_q_empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
